// File: rtl/icebus_pkg.sv
// icebus_pkg: shared constants and state types for the icebus responder.
// ICEBUS_CHECKSUM_EN selects 8-byte frames carrying a trailing XOR byte.
package icebus_pkg;

  localparam logic [7:0] SOF_REQ   = 8'h55;
  localparam logic [7:0] SOF_RSP   = 8'hAA;
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  localparam int FRAME_LEN_CHK   = 8;
  localparam int FRAME_LEN_NOCHK = 7;

`ifdef ICEBUS_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int FRAME_LEN = FRAME_LEN_NOCHK;
`endif

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_RX,
    ST_CHECK,
    ST_TX
  } state_e;

  typedef enum logic [1:0] {
    URX_IDLE,
    URX_START,
    URX_DATA,
    URX_STOP
  } urx_e;

endpackage

// File: rtl/icebus_uart.sv
// icebus_uart: byte-level 8N1 receiver and transmitter, LSB first.
// Ports: rx_i/tx_o line, rx byte strobe + framing error, tx start/rdy/busy.
module icebus_uart
  import icebus_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_i,
  input  logic       rx_en_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_ferr_o,
  output logic       rx_start_o,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_rdy_o,
  output logic       tx_busy_o,
  output logic       tx_o
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

  logic [1:0]    sync_q;
  logic          prev_q;
  urx_e          rst_q, rst_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [2:0]    rbit_q, rbit_d;
  logic [7:0]    rsh_q, rsh_d;
  logic          val_q, val_d;
  logic          ferr_q, ferr_d;
  logic          strt_q, strt_d;
  logic          rxs;

  logic [9:0]    tsh_q;
  logic [CW-1:0] tcnt_q;
  logic [3:0]    tbit_q;
  logic          busy_q;
  logic          tx_last;

  assign rxs = sync_q[1];

  // A start needs a falling edge, so a line held low after a
  // framing error is not mistaken for a fresh start bit.
  always_comb begin
    rst_d  = rst_q;
    rcnt_d = rcnt_q + 1'b1;
    rbit_d = rbit_q;
    rsh_d  = rsh_q;
    val_d  = 1'b0;
    ferr_d = 1'b0;
    strt_d = 1'b0;
    unique case (rst_q)
      URX_IDLE: begin
        rcnt_d = '0;
        if (prev_q && !rxs) rst_d = URX_START;
      end
      URX_START: begin
        if (rcnt_q == HALF) begin
          rcnt_d = '0;
          rbit_d = '0;
          if (!rxs) begin
            rst_d  = URX_DATA;
            strt_d = 1'b1;
          end else begin
            rst_d = URX_IDLE;
          end
        end
      end
      URX_DATA: begin
        if (rcnt_q == FULL) begin
          rcnt_d = '0;
          rsh_d  = {rxs, rsh_q[7:1]};
          rbit_d = rbit_q + 1'b1;
          if (rbit_q == 3'd7) rst_d = URX_STOP;
        end
      end
      URX_STOP: begin
        if (rcnt_q == FULL) begin
          rcnt_d = '0;
          rst_d  = URX_IDLE;
          val_d  = rxs;
          ferr_d = !rxs;
        end
      end
      default: rst_d = URX_IDLE;
    endcase
    if (!rx_en_i) begin
      rst_d  = URX_IDLE;
      rcnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      rst_q  <= URX_IDLE;
      rcnt_q <= '0;
      rbit_q <= '0;
      rsh_q  <= '0;
      val_q  <= 1'b0;
      ferr_q <= 1'b0;
      strt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= rxs;
      rst_q  <= rst_d;
      rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;
      rsh_q  <= rsh_d;
      val_q  <= val_d;
      ferr_q <= ferr_d;
      strt_q <= strt_d;
    end
  end

  assign rx_data_o  = rsh_q;
  assign rx_valid_o = val_q;
  assign rx_ferr_o  = ferr_q;
  assign rx_start_o = strt_q;

  // Ready also in the final stop-bit cycle: bytes go out back-to-back.
  assign tx_last  = busy_q && (tbit_q == 4'd9) && (tcnt_q == FULL);
  assign tx_rdy_o = !busy_q || tx_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tsh_q  <= '1;
      tcnt_q <= '0;
      tbit_q <= '0;
      busy_q <= 1'b0;
    end else if (tx_start_i && tx_rdy_o) begin
      tsh_q  <= {1'b1, tx_data_i, 1'b0};
      tcnt_q <= '0;
      tbit_q <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (tcnt_q == FULL) begin
        tcnt_q <= '0;
        tsh_q  <= {1'b1, tsh_q[9:1]};
        tbit_q <= tbit_q + 1'b1;
        if (tbit_q == 4'd9) busy_q <= 1'b0;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

  assign tx_busy_o = busy_q;
  assign tx_o      = tsh_q[0];

endmodule

// File: rtl/icebus_responder.sv
// icebus_responder: UART command node answering READ/WRITE frames.
// Ports: clk, reset_n, rx/tx, current_average in, setpoint out, err_count.
// Define ICEBUS_CHECKSUM_EN for 8-byte frames with an XOR check byte.
module icebus_responder
  import icebus_pkg::*;
#(
  parameter logic [7:0] NODE_ID = 8'h06,
  parameter int         CLK_DIV = 434,
  parameter int         TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic        tx,
  input  logic [31:0] current_average,
  output logic [31:0] setpoint,
  output logic        setpoint_valid,
  output logic [7:0]  err_count
);

  localparam logic [3:0] FL   = 4'(FRAME_LEN);
  localparam logic [3:0] LAST = 4'(FRAME_LEN - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q;
  logic [7:0]  rb_q [1:FRAME_LEN-1];
  logic [31:0] tmo_q;
  logic [7:0]  rsp_cmd_q;
  logic [31:0] rsp_pl_q;
  logic [31:0] sp_q;
  logic        spv_q;
  logic [7:0]  err_q;

  logic [7:0]  rx_data;
  logic        rx_valid, rx_ferr, rx_start;
  logic        tx_go, tx_rdy, tx_busy;
  logic [7:0]  tx_byte, rsp_byte;
  logic        err_inc, sp_load;
  logic        id_ok, cmd_ok, chk_ok, rsp_ok;
  logic        tmo_hit, last_rx, tx_done;
  logic [7:0]  f_cmd;
  logic [31:0] f_dat;

  icebus_uart #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_i       (rx),
    .rx_en_i    (state_q != ST_TX),
    .rx_data_o  (rx_data),
    .rx_valid_o (rx_valid),
    .rx_ferr_o  (rx_ferr),
    .rx_start_o (rx_start),
    .tx_start_i (tx_go),
    .tx_data_i  (tx_byte),
    .tx_rdy_o   (tx_rdy),
    .tx_busy_o  (tx_busy),
    .tx_o       (tx)
  );

  assign f_cmd  = rb_q[2];
  assign f_dat  = {rb_q[3], rb_q[4], rb_q[5], rb_q[6]};
  assign id_ok  = rb_q[1] == NODE_ID;
  assign cmd_ok = (f_cmd == CMD_READ) || (f_cmd == CMD_WRITE);

`ifdef ICEBUS_CHECKSUM_EN
  logic [7:0] rsp_chk;
  assign chk_ok = (SOF_REQ ^ rb_q[1] ^ rb_q[2] ^ rb_q[3] ^ rb_q[4]
                   ^ rb_q[5] ^ rb_q[6]) == rb_q[7];
  assign rsp_chk = SOF_RSP ^ NODE_ID ^ rsp_cmd_q ^ rsp_pl_q[31:24]
                 ^ rsp_pl_q[23:16] ^ rsp_pl_q[15:8] ^ rsp_pl_q[7:0];
`else
  assign chk_ok = 1'b1;
`endif

  assign rsp_ok  = id_ok && cmd_ok && chk_ok;
  assign tmo_hit = tmo_q >= 32'(TIMEOUT);
  assign last_rx = rx_valid && (idx_q == LAST);
  assign tx_done = (idx_q == FL) && !tx_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_HUNT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HUNT:
        if (rx_valid && rx_data == SOF_REQ) state_d = ST_RX;
      ST_RX:
        if (rx_ferr || tmo_hit) state_d = ST_HUNT;
        else if (last_rx)       state_d = ST_CHECK;
      ST_CHECK:
        state_d = rsp_ok ? ST_TX : ST_HUNT;
      ST_TX:
        if (tx_done) state_d = ST_HUNT;
      default:
        state_d = ST_HUNT;
    endcase
  end

  always_comb begin
    rsp_byte = SOF_RSP;
    case (idx_q[2:0])
      3'd1:    rsp_byte = NODE_ID;
      3'd2:    rsp_byte = rsp_cmd_q;
      3'd3:    rsp_byte = rsp_pl_q[31:24];
      3'd4:    rsp_byte = rsp_pl_q[23:16];
      3'd5:    rsp_byte = rsp_pl_q[15:8];
      3'd6:    rsp_byte = rsp_pl_q[7:0];
`ifdef ICEBUS_CHECKSUM_EN
      3'd7:    rsp_byte = rsp_chk;
`endif
      default: rsp_byte = SOF_RSP;
    endcase
  end

  // A framing error and a timeout in the same cycle count once.
  always_comb begin
    tx_go   = 1'b0;
    tx_byte = SOF_RSP;
    err_inc = 1'b0;
    sp_load = 1'b0;
    unique case (state_q)
      ST_HUNT:  err_inc = rx_ferr;
      ST_RX:    err_inc = rx_ferr || tmo_hit;
      ST_CHECK: begin
        unique case (1'b1)
          !id_ok:           err_inc = rx_ferr;
          id_ok && !rsp_ok: err_inc = 1'b1;
          rsp_ok: begin
            err_inc = rx_ferr;
            tx_go   = 1'b1;
            sp_load = f_cmd == CMD_WRITE;
          end
          default: ;
        endcase
      end
      ST_TX: begin
        tx_go   = tx_rdy && (idx_q < FL);
        tx_byte = rsp_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q     <= '0;
      tmo_q     <= '0;
      rsp_cmd_q <= '0;
      rsp_pl_q  <= '0;
      sp_q      <= '0;
      spv_q     <= 1'b0;
      err_q     <= '0;
    end else begin
      spv_q <= sp_load;
      if (sp_load) sp_q <= f_dat;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 1'b1;
      if (state_q == ST_RX && !rx_start) tmo_q <= tmo_q + 32'd1;
      else                               tmo_q <= '0;
      unique case (state_q)
        ST_HUNT:  idx_q <= 4'd1;
        ST_RX:    if (rx_valid) idx_q <= idx_q + 1'b1;
        ST_CHECK: begin
          idx_q     <= 4'd1;
          rsp_cmd_q <= f_cmd;
          rsp_pl_q  <= (f_cmd == CMD_READ) ? current_average : f_dat;
        end
        ST_TX:    if (tx_go) idx_q <= idx_q + 1'b1;
        default:  idx_q <= 4'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_RX && rx_valid) rb_q[idx_q[2:0]] <= rx_data;
  end

  assign setpoint       = sp_q;
  assign setpoint_valid = spv_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_icebus_responder.sv
// tb_icebus_responder: directed + random frames against a frame-level model.
// Build with ICEBUS_CHECKSUM_EN to exercise the 8-byte frame format.
`timescale 1ns/1ps
module tb_icebus_responder;

  localparam int         CLK_DIV = 8;
  localparam int         TIMEOUT = 200;
  localparam logic [7:0] NODE    = 8'h06;
`ifdef ICEBUS_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef logic [7:0] bq_t [$];

  logic        clk;
  logic        reset_n;
  logic        rx;
  logic        tx;
  logic [31:0] current_average;
  logic [31:0] setpoint;
  logic        setpoint_valid;
  logic [7:0]  err_count;

  int          checks    = 0;
  int          errors    = 0;
  int          m_err     = 0;
  int          m_sv      = 0;
  logic [31:0] m_sp      = 0;
  int          sv_pulses = 0;
  int          tx_starts = 0;
  logic [7:0]  txq [$];

  icebus_responder #(
    .NODE_ID (NODE),
    .CLK_DIV (CLK_DIV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx              (rx),
    .tx              (tx),
    .current_average (current_average),
    .setpoint        (setpoint),
    .setpoint_valid  (setpoint_valid),
    .err_count       (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (setpoint_valid === 1'b1) sv_pulses++;

  // Line-level decoder of the tx output into bytes.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      tx_starts++;
      repeat (CLK_DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge clk);
        b[i] = tx;
      end
      repeat (CLK_DIV) @(negedge clk);
      txq.push_back(b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t mk_frame(input logic [7:0] sof, input logic [7:0] id,
                                   input logic [7:0] cmd, input logic [31:0] d,
                                   input bit corrupt);
    bq_t q;
    logic [7:0] x;
    q.push_back(sof);
    q.push_back(id);
    q.push_back(cmd);
    for (int i = 3; i >= 0; i--) q.push_back(d[8*i +: 8]);
    if (CHK_EN) begin
      x = 8'h00;
      foreach (q[i]) x = x ^ q[i];
      q.push_back(corrupt ? 8'h00 : x);
    end
    return q;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx = stop_ok;
    repeat (CLK_DIV) @(negedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (CLK_DIV) @(negedge clk);
  endtask

  task automatic txn(input string tag, input logic [7:0] id,
                     input logic [7:0] cmd, input logic [31:0] d,
                     input logic [31:0] ca, input bit corrupt);
    bq_t f;
    bq_t exp;
    bit answer;
    int st0;
    logic [7:0] got;
    current_average = ca;
    txq.delete();
    f = mk_frame(8'h55, id, cmd, d, corrupt);
    answer = (id == NODE) && (cmd == 8'h01 || cmd == 8'h02)
             && !(corrupt && CHK_EN);
    if (answer) begin
      exp = mk_frame(8'hAA, NODE, cmd, (cmd == 8'h01) ? ca : d, 1'b0);
      if (cmd == 8'h02) begin
        m_sp = d;
        m_sv++;
      end
    end else if (id == NODE && m_err < 255) begin
      m_err++;
    end
    st0 = tx_starts;
    foreach (f[i]) send_byte(f[i], 1'b1);
    if (answer) begin
      for (int c = 0; c < 30 * CLK_DIV * 10 && txq.size() < exp.size(); c++)
        @(negedge clk);
      check({tag, "_len"}, 32'(txq.size()), 32'(exp.size()));
      foreach (exp[i]) begin
        got = (i < txq.size()) ? txq[i] : 8'hxx;
        check($sformatf("%s_b%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
      end
    end else begin
      repeat (20 * CLK_DIV) @(negedge clk);
      check({tag, "_silent"}, 32'(tx_starts - st0), 32'd0);
    end
    repeat (2 * CLK_DIV) @(negedge clk);
    check({tag, "_err"}, {24'd0, err_count}, 32'(m_err));
    check({tag, "_sp"}, setpoint, m_sp);
    check({tag, "_svp"}, 32'(sv_pulses), 32'(m_sv));
  endtask

  initial begin
    bq_t f;
    logic [7:0] cmd;
    logic [7:0] id;
    int r;
    int st0;
    reset_n = 1'b0;
    rx = 1'b1;
    current_average = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_sp", setpoint, 32'd0);
    check("rst_spv", {31'd0, setpoint_valid}, 32'd0);
    check("rst_err", {24'd0, err_count}, 32'd0);
    reset_n = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clk);

    txn("read", NODE, 8'h01, 32'h0, 32'hDEADBEEF, 1'b0);
    txn("write", NODE, 8'h02, 32'h00001234, $urandom, 1'b0);
    txn("foreign", 8'h07, 8'h01, 32'h0, 32'hDEADBEEF, 1'b0);
    txn("badchk", NODE, CHK_EN ? 8'h01 : 8'h33, 32'h0, 32'hDEADBEEF, 1'b1);

    send_byte(8'h55, 1'b1);
    send_byte(NODE, 1'b1);
    send_byte(8'h01, 1'b1);
    m_err++;
    repeat (TIMEOUT + 1) @(negedge clk);
    check("timeout_err", {24'd0, err_count}, 32'(m_err));
    txn("after_tmo", NODE, 8'h01, 32'h0, $urandom, 1'b0);

    send_byte(8'h55, 1'b1);
    send_byte(NODE, 1'b1);
    send_byte(8'h01, 1'b0);
    m_err++;
    repeat (2 * CLK_DIV) @(negedge clk);
    check("ferr_err", {24'd0, err_count}, 32'(m_err));
    txn("after_ferr", NODE, 8'h02, $urandom, $urandom, 1'b0);

    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(0, 5);
      cmd = (r < 2) ? 8'h01 : (r < 4) ? 8'h02 : 8'h7E;
      id = ($urandom_range(0, 4) == 0) ? 8'h09 : NODE;
      txn($sformatf("rnd%0d", i), id, cmd, $urandom, $urandom, 1'b0);
    end

    current_average = $urandom;
    txq.delete();
    f = mk_frame(8'h55, NODE, 8'h01, 32'h0, 1'b0);
    foreach (f[i]) send_byte(f[i], 1'b1);
    for (int c = 0; c < 4000 && !(txq.size() >= 2 && tx == 1'b0); c++)
      @(negedge clk);
    check("midrsp_reached", {31'd0, tx}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_sp", setpoint, 32'd0);
    check("abort_spv", {31'd0, setpoint_valid}, 32'd0);
    check("abort_err", {24'd0, err_count}, 32'd0);
    m_err = 0;
    m_sp = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    st0 = tx_starts;
    repeat (12 * CLK_DIV) @(negedge clk);
    check("no_resume", 32'(tx_starts - st0), 32'd0);
    txq.delete();
    txn("after_rst", NODE, 8'h01, 32'h0, $urandom, 1'b0);

    for (int i = 0; i < 254; i++) begin
      send_byte(8'($urandom), 1'b0);
      if (m_err < 255) m_err++;
    end
    repeat (2 * CLK_DIV) @(negedge clk);
    check("err_254", {24'd0, err_count}, 32'(m_err));
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom), 1'b0);
      if (m_err < 255) m_err++;
    end
    repeat (2 * CLK_DIV) @(negedge clk);
    check("err_sat", {24'd0, err_count}, 32'(m_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
